// File: rtl/lifo_pop_streamer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lifo_pkg                                                        |
// | Purpose  : Shared types and defaults for the LIFO stack and its pop        |
// |            streamer (FSM state encoding, default data width).              |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package lifo_pkg;

  // Word width shared by the stack and every consumer of it.
  localparam int LIFO_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lifo_pop_streamer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lifo_pop_streamer_if                                            |
// | Purpose  : Bundles the stack-read side and the valid/ready output stream   |
// |            of the pop streamer.                                            |
// | Ports    : read_en    pop request to the stack                             |
// |            lifo_data  stack data_out (1 clk after read_en)                 |
// |            lifo_empty stack empty flag                                     |
// |            m_valid / m_data / m_ready  output stream handshake             |
// |            master = streamer side, slave = stack + downstream side         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface lifo_pop_streamer_if #(
  parameter int DATA_WIDTH = lifo_pkg::LIFO_DATA_WIDTH
);
  logic                  read_en;
  logic [DATA_WIDTH-1:0] lifo_data;
  logic                  lifo_empty;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output read_en,
    input  lifo_data,
    input  lifo_empty,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  read_en,
    output lifo_data,
    output lifo_empty,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/lifo_pop_streamer_skid_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lifo_skid_buf                                                   |
// | Purpose  : 2-entry FIFO with registered outputs. Absorbs the stack's       |
// |            one-cycle read latency so downstream stalls never drop a word.  |
// | Ports    : clk, rst_n            clock, async active-low reset             |
// |            in_valid, in_data     write side (no back-pressure)             |
// |            out_valid, out_data   head entry, registered                    |
// |            out_ready             head consumed when out_valid & out_ready  |
// |            count[1:0]            current occupancy (0..2)                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lifo_skid_buf
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH = LIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  pop;

  // head_q is the output register; it is left untouched when the buffer
  // empties so out_data keeps showing the last word.
  always_comb begin
    pop     = out_ready && (count_q != 2'd0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (in_valid) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        case ({in_valid, pop})
          2'b11:   head_d = in_data;
          2'b10: begin
            tail_d  = in_data;
            count_d = 2'd2;
          end
          2'b01:   count_d = 2'd0;
          default: ;
        endcase
      end
      2'd2: begin
        // A write while full without a pop cannot happen under the
        // streamer's credit rule, so it is not handled here.
        if (pop) begin
          head_d = tail_q;
          if (in_valid) begin
            tail_d = in_data;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/lifo_pop_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lifo_pop_streamer                                               |
// | Purpose  : On a start pulse, pops a burst of words from the LIFO stack     |
// |            (fixed count, or until empty) and streams them out on a         |
// |            valid/ready interface through a 2-entry skid buffer.            |
// | Ports    : clk, rst_n      clock, async active-low reset                   |
// |            start           one-cycle pulse, sampled only in IDLE           |
// |            burst_len       words to pop, 0 = until empty                   |
// |            busy            high in POP and DRAIN                           |
// |            done            one-cycle pulse after the last word left        |
// |            pop_count       total words popped since reset (wraps)          |
// |            bus (master)    read_en/lifo_data/lifo_empty, m_valid/m_data/   |
// |                            m_ready                                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lifo_pop_streamer
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH = LIFO_DATA_WIDTH,
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pop_count,
  lifo_pop_streamer_if.master  bus
);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  pop_count_q, pop_count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [1:0]            buf_count;
  logic                  out_fire;
  logic [1:0]            occupancy;
  logic                  credit_ok;
  logic                  buf_drained;
  logic                  limit_hit;
  logic                  read_en;

  assign out_fire = buf_valid && bus.m_ready;

  // Words that will still need a buffer slot after this cycle: the one in
  // flight plus those not leaving now. Counting the departing word as free
  // is what allows one word per clock with m_ready held high.
  assign occupancy   = 2'(inflight_q) + buf_count - 2'(out_fire);
  assign credit_ok   = (occupancy < 2'd2) && (buf_count != 2'd2);
  assign buf_drained = (buf_count == 2'd0) || ((buf_count == 2'd1) && out_fire);
  assign limit_hit   = (len_q != '0) && (issued_q == len_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    read_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = burst_len;
          issued_d = '0;
          state_d  = POP;
        end
      end
      POP: begin
        read_en = !bus.lifo_empty && credit_ok && !limit_hit;
        if (read_en) begin
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        // Pop-until-empty ends as soon as the stack reports empty; a fixed
        // burst ignores empty and waits for more pushes.
        if (limit_hit || ((len_q == '0) && bus.lifo_empty)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && buf_drained) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // read_en already implies the stack was non-empty.
    inflight_d  = read_en;
    pop_count_d = pop_count_q + CNT_WIDTH'(read_en);
    busy_d      = (state_d == POP) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      pop_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      pop_count_q <= pop_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The word requested last cycle is on lifo_data now.
  lifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight_q),
    .in_data   (bus.lifo_data),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .out_ready (bus.m_ready),
    .count     (buf_count)
  );

  assign bus.read_en = read_en;
  assign bus.m_valid = buf_valid;
  assign bus.m_data  = buf_data;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pop_count   = pop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lifo_pop_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lifo_pop_streamer                                            |
// | Purpose  : Self-checking bench for lifo_pop_streamer: behavioural stack,   |
// |            output collector, directed and randomized bursts.               |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_lifo_pop_streamer;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic [CW-1:0] pop_count;

  lifo_pop_streamer_if #(.DATA_WIDTH(DW)) bus ();

  lifo_pop_streamer #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .pop_count (pop_count),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stack: top of stack is the back of the queue.
  logic [DW-1:0] stk[$];
  logic          push_en  = 1'b0;
  logic [DW-1:0] push_val = '0;
  always @(posedge clk) begin
    if (bus.read_en && !bus.lifo_empty) bus.lifo_data <= stk.pop_back();
    if (push_en) stk.push_back(push_val);
    bus.lifo_empty <= (stk.size() == 0);
  end

  // Downstream ready: 0 = always, 1 = 1,0,0 repeating, 2 = random.
  int ready_mode = 0;
  int rphase     = 0;
  always @(negedge clk) begin
    case (ready_mode)
      0: bus.m_ready = 1'b1;
      1: begin
        bus.m_ready = (rphase == 0);
        rphase      = (rphase == 2) ? 0 : rphase + 1;
      end
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Collector: records transfers and protocol events.
  logic [DW-1:0] got_q[$];
  int            xfer_cyc_q[$];
  int            reads = 0, disc = 0;
  int            hold_viol = 0, uflow_viol = 0, credit_viol = 0;
  int            done_cnt = 0, done_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  always @(posedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      disc       = reads - xfer_cyc_q.size();
    end else begin
      if (prev_stall && !(bus.m_valid === 1'b1 && bus.m_data === prev_data)) hold_viol++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back(bus.m_data);
        xfer_cyc_q.push_back(cyc);
      end
      if (bus.read_en) begin
        reads++;
        if (bus.lifo_empty) uflow_viol++;
        // Words popped but not yet delivered must fit in two slots.
        if (reads - disc - xfer_cyc_q.size() > 2) credit_viol++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int vectors     = 0;
  int miscompares = 0;
  int exp_pops    = 0;
  logic [DW-1:0] exp_q[$];
  int st_cyc, base_got, base_done, base_hold, base_uflow, base_credit;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    @(negedge clk);
    push_en  = 1'b1;
    push_val = v;
    @(negedge clk);
    push_en  = 1'b0;
  endtask

  // Expected burst: top `len` words of the stack (all of it for len 0).
  task automatic set_expect(input int len);
    int n;
    exp_q.delete();
    n = (len == 0) ? stk.size() : len;
    for (int i = 0; i < n; i++) exp_q.push_back(stk[stk.size() - 1 - i]);
  endtask

  task automatic begin_burst(input int len);
    @(negedge clk);
    base_got    = got_q.size();
    base_done   = done_cnt;
    base_hold   = hold_viol;
    base_uflow  = uflow_viol;
    base_credit = credit_viol;
    st_cyc      = cyc;
    start       = 1'b1;
    burst_len   = LW'(len);
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic finish_burst(input string name, input bit tput);
    int waited = 0;
    int n_got;
    while (done_cnt == base_done && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check({name, " done_seen"}, 64'(waited < 3000), 1);
    repeat (3) @(negedge clk);
    n_got = got_q.size() - base_got;
    check({name, " words"}, n_got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_got; i++)
      check($sformatf("%s word%0d", name, i), got_q[base_got + i], exp_q[i]);
    check({name, " done_pulses"}, done_cnt - base_done, 1);
    if (n_got > 0 && exp_q.size() > 0) begin
      check({name, " done_lat"}, 64'(done_cyc - xfer_cyc_q[$]), 1);
      if (tput)
        check({name, " back_to_back"}, 64'(xfer_cyc_q[$] - xfer_cyc_q[base_got]), n_got - 1);
    end
    check({name, " hold"},      hold_viol - base_hold, 0);
    check({name, " underflow"}, uflow_viol - base_uflow, 0);
    check({name, " credit"},    credit_viol - base_credit, 0);
    exp_pops += exp_q.size();
    check({name, " pop_count"}, pop_count, CW'(exp_pops));
    check({name, " busy_after"}, busy, 0);
  endtask

  task automatic run_burst(input string name, input int len, input bit tput);
    set_expect(len);
    begin_burst(len);
    finish_burst(name, tput);
  endtask

  initial begin
    int waited, n, len;
    rst_n     = 1'b0;
    start     = 1'b0;
    burst_len = '0;

    #1;
    check("rst busy",      busy,        0);
    check("rst done",      done,        0);
    check("rst read_en",   bus.read_en, 0);
    check("rst m_valid",   bus.m_valid, 0);
    check("rst m_data",    bus.m_data,  0);
    check("rst pop_count", pop_count,   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1) pop until empty at full throughput
    for (int v = 35; v >= 5; v -= 5) push_word(DW'(v));
    ready_mode = 0;
    run_burst("t1_all", 0, 1'b1);

    // 2) fixed burst of 3 from the same stack
    for (int v = 35; v >= 5; v -= 5) push_word(DW'(v));
    run_burst("t2_fixed3", 3, 1'b1);
    check("t2 stack_left", stk.size(), 4);
    run_burst("t2_rest", 0, 1'b1);

    // 3) stalling downstream
    for (int i = 0; i < 7; i++) push_word(DW'($urandom));
    ready_mode = 1;
    run_burst("t3_toggle", 0, 1'b0);

    // 4) fixed burst from an empty stack stalls until pushes arrive
    ready_mode = 0;
    exp_q.delete();
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd9);
    begin_burst(2);
    repeat (4) @(negedge clk);
    check("t4 stall read_en", bus.read_en, 0);
    check("t4 stall busy",    busy,        1);
    push_word(8'd7);
    repeat (3) @(negedge clk);
    push_word(8'd9);
    finish_burst("t4_stall", 1'b0);

    // 5) asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) push_word(DW'($urandom));
    begin_burst(0);
    waited = 0;
    while (got_q.size() - base_got < 2 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("t5 reached", 64'(waited < 200), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 m_valid",   bus.m_valid, 0);
    check("t5 busy",      busy,        0);
    check("t5 read_en",   bus.read_en, 0);
    check("t5 pop_count", pop_count,   0);
    exp_pops = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5 idle busy",    busy,        0);
    check("t5 idle m_valid", bus.m_valid, 0);
    run_burst("t5_after", 0, 1'b1);

    // 6) start while busy is ignored; mode-0 burst on empty stack
    for (int i = 0; i < 5; i++) push_word(DW'($urandom));
    ready_mode = 1;
    set_expect(2);
    begin_burst(2);
    repeat (2) @(negedge clk);
    start     = 1'b1;
    burst_len = '0;
    @(negedge clk);
    start     = 1'b0;
    finish_burst("t6_ignored", 1'b0);
    ready_mode = 2;
    run_burst("t6_rest", 0, 1'b0);
    ready_mode = 0;
    run_burst("t6_empty", 0, 1'b0);
    // start sampled at st_cyc; POP, DRAIN, DONE follow on successive edges
    check("t6 empty done_lat", 64'(done_cyc - st_cyc), 3);

    // randomized bursts
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) push_word(DW'($urandom));
      len        = $urandom_range(0, stk.size() > 15 ? 15 : stk.size());
      ready_mode = $urandom_range(0, 2);
      run_burst($sformatf("rnd%0d", k), len, ready_mode == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
